dz_count_ctrl: RTL

Sequencing controller for the 8×8 dot-matrix digit display. It runs a start/pause countdown from `START_NUM` to 0 and drives the display's `num` input. It also generates the row-scan index and the active-low row select that the display datapath consumes. It sits between the board buttons (already debounced and converted to one-cycle pulses) and the dot-matrix display block.

---
 rtl/dz_pkg.sv | 20 ++
 rtl/dz_divider.sv | 30 +++
 rtl/dz_count_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/dz_pkg.sv
// rtl/dz_pkg.sv - shared types and constants for the dot-matrix countdown controller
package dz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } dz_state_t;

    localparam int DZ_ROWS             = 8;
    localparam int DZ_TICK_DIV_DEFAULT = 50_000_000;
    localparam int DZ_SCAN_DIV_DEFAULT = 5_000;

    // Counter width for a modulo-n count; a modulo-1 counter still needs one bit.
    function automatic int dz_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dz_divider.sv
// rtl/dz_divider.sv - modulo-N counter with enable, clear and a wrap pulse
module dz_divider
    import dz_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = dz_cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    // wrap is combinational so the consumer acts on the same edge the count returns to 0
    assign wrap = en && !clr && (count == W'(N - 1));

    // count 0..N-1; clear beats enable, disabled count holds its phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/dz_count_ctrl.sv
// rtl/dz_count_ctrl.sv - countdown/scan sequencer for the 8x8 digit display (option: DZ_COUNT_BLINK_EN)
module dz_count_ctrl
    import dz_pkg::*;
#(
    parameter int TICK_DIV  = DZ_TICK_DIV_DEFAULT,
    parameter int SCAN_DIV  = DZ_SCAN_DIV_DEFAULT,
    parameter int START_NUM = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    output logic [2:0]         num,
    output logic [2:0]         row_count,
    output logic [DZ_ROWS-1:0] row,
    output logic               busy,
    output logic               done,
    output logic               blank
);

    localparam int TW = dz_cnt_width(TICK_DIV);
    localparam int SW = dz_cnt_width(SCAN_DIV);

    dz_state_t         state;
    logic              tick_en;
    logic              tick_wrap;
    logic              scan_wrap;
    logic [TW-1:0]     unused_tick_count;
    logic [SW-1:0]     unused_scan_count;

`ifdef DZ_COUNT_BLINK_EN
    // the tick keeps running after the count ends so it can pace the blink
    assign tick_en = (state == ST_RUN) || (state == ST_DONE);
`else
    assign tick_en = (state == ST_RUN);
`endif

    dz_divider #(.N(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (tick_en),
        .clr   (start),
        .count (unused_tick_count),
        .wrap  (tick_wrap)
    );

    dz_divider #(.N(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .clr   (1'b0),
        .count (unused_scan_count),
        .wrap  (scan_wrap)
    );

    // row index and its active-low one-hot select advance together on every scan wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_count <= 3'd0;
            row       <= 8'hFE;
        end else if (scan_wrap) begin
            row_count <= row_count + 3'd1;
            row       <= ~(8'b0000_0001 << (row_count + 3'd1));
        end
    end

    // countdown FSM with registered num/busy/done/blank; start has priority over pause
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            num   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            blank <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state <= ST_RUN;
                num   <= 3'(START_NUM);
                busy  <= 1'b1;
                blank <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (tick_wrap) begin
                            if (num <= 3'd1) begin
                                num   <= 3'd0;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                blank <= 1'b0;
                                state <= ST_DONE;
                            end else begin
                                num <= num - 3'd1;
                                if (pause) state <= ST_PAUSE;
                            end
                        end else if (pause) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (pause) state <= ST_RUN;
                    end
                    ST_DONE: begin
`ifdef DZ_COUNT_BLINK_EN
                        if (tick_wrap) blank <= ~blank;
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
